rob_retire: RTL

- 16-entry reorder buffer and in-order commit stage of the 2-wide out-of-order RISC-V core. Sits downstream of dispatch.
- Dispatch allocates up to 2 rows per cycle in program order. Functional units mark rows complete by ROB index.
- Up to 2 oldest completed rows retire per cycle. Each retiring row releases its old physical destination back to the free pool.

---
 rtl/rob_retire_pkg.sv | 17 +
 rtl/rob_retire_commit_sel.sv | 15 +
 rtl/rob_retire.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder buffer and its commit selector.
package rob_retire_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int ROB_PC_W  = 32;

  typedef struct packed {
    logic        v;
    logic        complete;
    logic [4:0]  dest_reg;
    logic [5:0]  pd;
    logic [5:0]  old_dest_reg;
    logic [31:0] pc;
  } rob_row_t;

endpackage

// File: rtl/rob_retire_commit_sel.sv
// Retire-enable selection for the two oldest ROB rows; pure combinational.
module rob_commit_sel (
  input  logic head_v_i,
  input  logic head_cmpl_i,
  input  logic next_v_i,
  input  logic next_cmpl_i,
  output logic ret_en_1_o,
  output logic ret_en_2_o
);

  // Lane 2 may only retire behind lane 1 so commit stays strictly in order.
  assign ret_en_1_o = head_v_i & head_cmpl_i;
  assign ret_en_2_o = ret_en_1_o & next_v_i & next_cmpl_i;

endmodule

// File: rtl/rob_retire.sv
// 16-entry reorder buffer with 2-wide allocate, 2-port completion and 2-wide in-order retire.
// Optional synchronous flush port enabled by defining ROB_FLUSH_EN.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int PC_W  = ROB_PC_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             alloc_v_1,
  input  logic [4:0]       alloc_rd_1,
  input  logic [5:0]       alloc_pd_1,
  input  logic [5:0]       alloc_old_pd_1,
  input  logic [PC_W-1:0]  alloc_pc_1,
  input  logic             alloc_v_2,
  input  logic [4:0]       alloc_rd_2,
  input  logic [5:0]       alloc_pd_2,
  input  logic [5:0]       alloc_old_pd_2,
  input  logic [PC_W-1:0]  alloc_pc_2,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx_1,
  output logic [IDX_W-1:0] alloc_idx_2,
  input  logic             cmpl_v_1,
  input  logic [IDX_W-1:0] cmpl_idx_1,
  input  logic             cmpl_v_2,
  input  logic [IDX_W-1:0] cmpl_idx_2,
  output logic             ret_v_1,
  output logic [4:0]       ret_rd_1,
  output logic [5:0]       ret_pd_1,
  output logic [5:0]       ret_old_pd_1,
  output logic [PC_W-1:0]  ret_pc_1,
  output logic             ret_free_v_1,
  output logic             ret_v_2,
  output logic [4:0]       ret_rd_2,
  output logic [5:0]       ret_pd_2,
  output logic [5:0]       ret_old_pd_2,
  output logic [PC_W-1:0]  ret_pc_2,
  output logic             ret_free_v_2,
  output logic [IDX_W:0]   rob_count,
  output logic             rob_empty
);

  // Handshake: an allocate lane is accepted on a rising edge when alloc_ready
  // and its alloc_v are both high; lane 2 additionally needs lane 1. There is
  // no backpressure on completion or retire.

  rob_row_t         rows_q [DEPTH];
  rob_row_t         rows_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             ret_v_1_q, ret_v_1_d, ret_v_2_q, ret_v_2_d;
  logic             ret_free_1_q, ret_free_1_d, ret_free_2_q, ret_free_2_d;
  logic [4:0]       ret_rd_1_q, ret_rd_1_d, ret_rd_2_q, ret_rd_2_d;
  logic [5:0]       ret_pd_1_q, ret_pd_1_d, ret_pd_2_q, ret_pd_2_d;
  logic [5:0]       ret_opd_1_q, ret_opd_1_d, ret_opd_2_q, ret_opd_2_d;
  logic [PC_W-1:0]  ret_pc_1_q, ret_pc_1_d, ret_pc_2_q, ret_pc_2_d;

  logic [IDX_W-1:0] head_p1, tail_p1;
  logic             do_alloc_1, do_alloc_2;
  logic             ret_en_1, ret_en_2;
  logic [IDX_W:0]   n_alloc, n_ret;
  logic             kill;
  rob_row_t         head_row, next_row;

`ifdef ROB_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign head_p1  = head_q + 1'b1;
  assign tail_p1  = tail_q + 1'b1;
  assign head_row = rows_q[head_q];
  assign next_row = rows_q[head_p1];

  // Uses the pre-commit count, so a row freed this cycle is never reused this cycle.
  assign alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
  assign do_alloc_1  = alloc_ready & alloc_v_1;
  assign do_alloc_2  = do_alloc_1 & alloc_v_2;

  rob_commit_sel u_commit_sel (
    .head_v_i    (head_row.v),
    .head_cmpl_i (head_row.complete),
    .next_v_i    (next_row.v),
    .next_cmpl_i (next_row.complete),
    .ret_en_1_o  (ret_en_1),
    .ret_en_2_o  (ret_en_2)
  );

  assign n_alloc = (IDX_W+1)'(do_alloc_1) + (IDX_W+1)'(do_alloc_2);
  assign n_ret   = (IDX_W+1)'(ret_en_1) + (IDX_W+1)'(ret_en_2);

  always_comb begin
    rows_d = rows_q;
    if (cmpl_v_1 && rows_q[cmpl_idx_1].v) rows_d[cmpl_idx_1].complete = 1'b1;
    if (cmpl_v_2 && rows_q[cmpl_idx_2].v) rows_d[cmpl_idx_2].complete = 1'b1;
    if (ret_en_1) begin
      rows_d[head_q].v        = 1'b0;
      rows_d[head_q].complete = 1'b0;
    end
    if (ret_en_2) begin
      rows_d[head_p1].v        = 1'b0;
      rows_d[head_p1].complete = 1'b0;
    end
    if (do_alloc_1)
      rows_d[tail_q] = '{v: 1'b1, complete: 1'b0, dest_reg: alloc_rd_1, pd: alloc_pd_1,
                         old_dest_reg: alloc_old_pd_1, pc: alloc_pc_1};
    if (do_alloc_2)
      rows_d[tail_p1] = '{v: 1'b1, complete: 1'b0, dest_reg: alloc_rd_2, pd: alloc_pd_2,
                          old_dest_reg: alloc_old_pd_2, pc: alloc_pc_2};
    head_d  = head_q + n_ret[IDX_W-1:0];
    tail_d  = tail_q + n_alloc[IDX_W-1:0];
    count_d = count_q + n_alloc - n_ret;

    ret_v_1_d    = ret_en_1;
    ret_free_1_d = ret_en_1 & (head_row.dest_reg != 5'd0);
    ret_rd_1_d   = ret_en_1 ? head_row.dest_reg     : '0;
    ret_pd_1_d   = ret_en_1 ? head_row.pd           : '0;
    ret_opd_1_d  = ret_en_1 ? head_row.old_dest_reg : '0;
    ret_pc_1_d   = ret_en_1 ? head_row.pc           : '0;
    ret_v_2_d    = ret_en_2;
    ret_free_2_d = ret_en_2 & (next_row.dest_reg != 5'd0);
    ret_rd_2_d   = ret_en_2 ? next_row.dest_reg     : '0;
    ret_pd_2_d   = ret_en_2 ? next_row.pd           : '0;
    ret_opd_2_d  = ret_en_2 ? next_row.old_dest_reg : '0;
    ret_pc_2_d   = ret_en_2 ? next_row.pc           : '0;

    // Flush wins over everything happening in the same cycle.
    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        rows_d[i].v        = 1'b0;
        rows_d[i].complete = 1'b0;
      end
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      ret_v_1_d    = 1'b0;
      ret_v_2_d    = 1'b0;
      ret_free_1_d = 1'b0;
      ret_free_2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret_v_1_q    <= 1'b0;
      ret_free_1_q <= 1'b0;
      ret_rd_1_q   <= '0;
      ret_pd_1_q   <= '0;
      ret_opd_1_q  <= '0;
      ret_pc_1_q   <= '0;
      ret_v_2_q    <= 1'b0;
      ret_free_2_q <= 1'b0;
      ret_rd_2_q   <= '0;
      ret_pd_2_q   <= '0;
      ret_opd_2_q  <= '0;
      ret_pc_2_q   <= '0;
    end else begin
      rows_q       <= rows_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ret_v_1_q    <= ret_v_1_d;
      ret_free_1_q <= ret_free_1_d;
      ret_rd_1_q   <= ret_rd_1_d;
      ret_pd_1_q   <= ret_pd_1_d;
      ret_opd_1_q  <= ret_opd_1_d;
      ret_pc_1_q   <= ret_pc_1_d;
      ret_v_2_q    <= ret_v_2_d;
      ret_free_2_q <= ret_free_2_d;
      ret_rd_2_q   <= ret_rd_2_d;
      ret_pd_2_q   <= ret_pd_2_d;
      ret_opd_2_q  <= ret_opd_2_d;
      ret_pc_2_q   <= ret_pc_2_d;
    end
  end

  assign alloc_idx_1  = tail_q;
  assign alloc_idx_2  = tail_p1;
  assign rob_count    = count_q;
  assign rob_empty    = (count_q == '0);
  assign ret_v_1      = ret_v_1_q;
  assign ret_free_v_1 = ret_free_1_q;
  assign ret_rd_1     = ret_rd_1_q;
  assign ret_pd_1     = ret_pd_1_q;
  assign ret_old_pd_1 = ret_opd_1_q;
  assign ret_pc_1     = ret_pc_1_q;
  assign ret_v_2      = ret_v_2_q;
  assign ret_free_v_2 = ret_free_2_q;
  assign ret_rd_2     = ret_rd_2_q;
  assign ret_pd_2     = ret_pd_2_q;
  assign ret_old_pd_2 = ret_opd_2_q;
  assign ret_pc_2     = ret_pc_2_q;

endmodule
